inst_queue: RTL

Two-wide instruction queue between decode and `issue`. It buffers decoded instruction pairs (instruction, control bus, branch prediction bit and predicted target) from decode. Each cycle it presents the two oldest entries to `issue` as slot 0 and slot 1. When `issue` holds back slot 1, only slot 0 retires, and the held instruction is re-presented as slot 0 the next cycle, so program order is preserved.

---
 rtl/inst_queue_pkg.sv | 13 +
 rtl/inst_queue_mem.sv | 31 +++
 rtl/inst_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue shared constants and entry layout.
// Entry = {inst[31:0], ctrl[CTRL_W-1:0], pred, tgt[31:0]}.
package inst_queue_pkg;

  localparam int IQ_CTRL_W = 16;
  localparam int IQ_INST_W = 32;
  localparam int IQ_TGT_W  = 32;

  function automatic int iq_ent_w(input int cw);
    return IQ_INST_W + cw + 1 + IQ_TGT_W;
  endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// inst_queue entry storage: DEPTH x W regs, no reset.
// Ports: clock_i; we0/wa0/wd0, we1/wa1/wd1 writes; ra0/rd0, ra1/rd1 async reads.
module inst_queue_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 81,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock_i,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra0,
  output logic [W-1:0]  rd0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_queue.sv
// Two-wide decode->issue instruction queue (circular buffer).
// Ports: enq0/enq1 payload+valids in, slot0/slot1 gated payload out, count_o.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CTRL_W = IQ_CTRL_W
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       enq0_valid_i,
  input  logic                       enq1_valid_i,
  input  logic [31:0]                enq0_inst_i,
  input  logic [31:0]                enq1_inst_i,
  input  logic [CTRL_W-1:0]          enq0_ctrl_i,
  input  logic [CTRL_W-1:0]          enq1_ctrl_i,
  input  logic                       enq0_pred_i,
  input  logic                       enq1_pred_i,
  input  logic [31:0]                enq0_pred_tgt_i,
  input  logic [31:0]                enq1_pred_tgt_i,
  output logic                       enq_ready_o,
  input  logic                       stall_i,
  input  logic                       issue1_stall_i,
  output logic [31:0]                inst0_o,
  output logic [31:0]                inst1_o,
  output logic [CTRL_W-1:0]          ctrl0_o,
  output logic [CTRL_W-1:0]          ctrl1_o,
  output logic                       pred_0_o,
  output logic                       pred_1_o,
  output logic [31:0]                pred_tgt_0_o,
  output logic [31:0]                pred_tgt_1_o,
  output logic                       valid0_o,
  output logic                       valid1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = iq_ent_w(CTRL_W);

  logic [AW-1:0] hd, tl;
  logic [CW-1:0] count;
  logic [1:0]    n_enq, n_deq;
  logic          we0, we1;
  logic [EW-1:0] wd0, wd1, rd0, rd1;

  assign enq_ready_o = count <= CW'(DEPTH - 2);
  assign valid0_o    = count != '0;
  assign valid1_o    = count >= CW'(2);
  assign count_o     = count;

  always_comb begin
    n_enq = 2'd0;
    if (enq_ready_o && enq0_valid_i)
      n_enq = enq1_valid_i ? 2'd2 : 2'd1;
  end

  always_comb begin
    n_deq = 2'd0;
    if (stall_i)
      n_deq = 2'd0;
    else if (issue1_stall_i)
      n_deq = {1'b0, valid0_o};
    else
      n_deq = {valid1_o, valid0_o & ~valid1_o};
  end

  assign we0 = ~flush_i & (n_enq != 2'd0);
  assign we1 = ~flush_i & (n_enq == 2'd2);

  assign wd0 = {enq0_inst_i, enq0_ctrl_i,
                enq0_pred_i, enq0_pred_tgt_i};
  assign wd1 = {enq1_inst_i, enq1_ctrl_i,
                enq1_pred_i, enq1_pred_tgt_i};

  inst_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_mem (
    .clock_i (clock_i),
    .we0     (we0),
    .wa0     (tl),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (tl + AW'(1)),
    .wd1     (wd1),
    .ra0     (hd),
    .rd0     (rd0),
    .ra1     (hd + AW'(1)),
    .rd1     (rd1)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (flush_i) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      hd    <= hd + AW'(n_deq);
      tl    <= tl + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Invalid slots present a zero bubble (zero ctrl reads as NOP).
  always_comb begin
    inst0_o      = '0;
    ctrl0_o      = '0;
    pred_0_o     = 1'b0;
    pred_tgt_0_o = '0;
    inst1_o      = '0;
    ctrl1_o      = '0;
    pred_1_o     = 1'b0;
    pred_tgt_1_o = '0;
    if (valid0_o) begin
      inst0_o      = rd0[EW-1 -: 32];
      ctrl0_o      = rd0[33 +: CTRL_W];
      pred_0_o     = rd0[32];
      pred_tgt_0_o = rd0[31:0];
    end
    if (valid1_o) begin
      inst1_o      = rd1[EW-1 -: 32];
      ctrl1_o      = rd1[33 +: CTRL_W];
      pred_1_o     = rd1[32];
      pred_tgt_1_o = rd1[31:0];
    end
  end

endmodule
